// File: rtl/fv_bank_stream_tx.sv
// fv_bank_stream_tx: fetches rows from memory one at a time. Each row holds one
// word per FV bank, and every row is broadcast to all banks as a single write
// beat. Only one memory read is outstanding at any time. All outputs come
// straight from registers.
module fv_bank_stream_tx #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int MAX_FV    = 64,
    parameter int MADDR_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(MAX_FV):0]     num_fv,
    input  logic [MADDR_W-1:0]          base_addr,
    output logic                        mem_req,
    output logic [MADDR_W-1:0]          mem_addr,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata,
    output logic                        bank_valid,
    output logic                        bank_sos,
    output logic                        bank_eos,
    output logic [ADDR_W-1:0]           bank_A,
    output logic [NUM_BANKS*DATA_W-1:0] bank_data,
    input  logic                        bank_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int NF_W = $clog2(MAX_FV) + 1;
    localparam int BW   = NUM_BANKS * DATA_W;
    // The row counter is wide enough to drive the row count compare, bank_A
    // truncation and the memory address add without any unused bits.
    localparam int RW_A = (NF_W > ADDR_W) ? NF_W : ADDR_W;
    localparam int RW   = (RW_A > MADDR_W) ? RW_A : MADDR_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [NF_W-1:0]    r_num;
    logic [MADDR_W-1:0] r_base;
    logic [RW-1:0]      r_row;
    logic [BW-1:0]      r_buf;

    logic               r_mem_req;
    logic [MADDR_W-1:0] r_mem_addr;
    logic               r_bank_valid;
    logic               r_bank_sos;
    logic               r_bank_eos;
    logic [ADDR_W-1:0]  r_bank_a;
    logic [BW-1:0]      r_bank_data;
    logic               r_busy;
    logic               r_done;

    logic [2:0]         w_state_nx;
    logic [NF_W-1:0]    w_num_nx;
    logic [MADDR_W-1:0] w_base_nx;
    logic [RW-1:0]      w_row_nx;
    logic [BW-1:0]      w_buf_nx;
    logic [NF_W-1:0]    w_num_clamp;

    // True when row index 'row' is the final row of a load of 'num' rows.
    function automatic logic is_last_row(input logic [RW-1:0] row,
                                         input logic [NF_W-1:0] num);
        return row == (RW'(num) - RW'(1'b1));
    endfunction

    assign w_num_clamp = (num_fv > NF_W'(MAX_FV)) ? NF_W'(MAX_FV) : num_fv;

    // Next-state logic: load sequencing and capture of each row as it returns.
    always_comb begin
        w_state_nx = r_state;
        w_num_nx   = r_num;
        w_base_nx  = r_base;
        w_row_nx   = r_row;
        w_buf_nx   = r_buf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_fv != {NF_W{1'b0}}) begin
                        w_num_nx   = w_num_clamp;
                        w_base_nx  = base_addr;
                        w_row_nx   = {RW{1'b0}};
                        w_state_nx = S_REQ;
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_state_nx = S_WAIT;
                end else begin
                    w_state_nx = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_buf_nx   = mem_rdata;
                    w_state_nx = S_SEND;
                end else begin
                    w_state_nx = S_WAIT;
                end
            end
            S_SEND: begin
                if (bank_ready) begin
                    if (is_last_row(r_row, r_num)) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_row_nx   = r_row + RW'(1'b1);
                        w_state_nx = S_REQ;
                    end
                end else begin
                    w_state_nx = S_SEND;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State, load context and output registers. The outputs are computed from
    // the next state, so each one is valid in the same cycle as its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_num        <= {NF_W{1'b0}};
            r_base       <= {MADDR_W{1'b0}};
            r_row        <= {RW{1'b0}};
            r_buf        <= {BW{1'b0}};
            r_mem_req    <= 1'b0;
            r_mem_addr   <= {MADDR_W{1'b0}};
            r_bank_valid <= 1'b0;
            r_bank_sos   <= 1'b0;
            r_bank_eos   <= 1'b0;
            r_bank_a     <= {ADDR_W{1'b0}};
            r_bank_data  <= {BW{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_num      <= w_num_nx;
            r_base     <= w_base_nx;
            r_row      <= w_row_nx;
            r_buf      <= w_buf_nx;
            r_mem_req  <= (w_state_nx == S_REQ);
            r_mem_addr <= (w_state_nx == S_REQ) ?
                          (w_base_nx + w_row_nx[MADDR_W-1:0]) : {MADDR_W{1'b0}};
            if (w_state_nx == S_SEND) begin
                r_bank_valid <= 1'b1;
                r_bank_sos   <= (w_row_nx == {RW{1'b0}});
                r_bank_eos   <= is_last_row(w_row_nx, w_num_nx);
                r_bank_a     <= w_row_nx[ADDR_W-1:0];
                r_bank_data  <= w_buf_nx;
            end else begin
                r_bank_valid <= 1'b0;
                r_bank_sos   <= 1'b0;
                r_bank_eos   <= 1'b0;
                r_bank_a     <= {ADDR_W{1'b0}};
                r_bank_data  <= {BW{1'b0}};
            end
            r_busy <= (w_state_nx != S_IDLE);
            r_done <= (w_state_nx == S_DONE);
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign bank_valid = r_bank_valid;
    assign bank_sos   = r_bank_sos;
    assign bank_eos   = r_bank_eos;
    assign bank_A     = r_bank_a;
    assign bank_data  = r_bank_data;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
